mmio_uart_tx: RTL
=================

# mmio_uart_tx

Memory-mapped UART transmitter peripheral on the core's data bus, alongside the LED register in the MMIO space at 0x8000_xxxx. The CPU stores bytes to a data register. They are queued in an 8-entry FIFO and serialized 8N1, LSB first, on `uart_tx`. A status register lets firmware poll for space before storing. The top level ORs `hit` into its read-data mux so loads from this block's addresses bypass DMEM.

## Interface
- `CLKS_PER_BIT`, default 108: core clock cycles per UART bit (12.5 MHz core / 115200 baud). Must be ≥ 2.
- `FIFO_DEPTH`, default 8: TX FIFO entries. Power of two, ≥ 2.
- `BASE_ADDR`, default 32'h8000_0010: address of TXDATA. STATUS is at `BASE_ADDR`+4.
- `clk`  in  1  core clock (the CPU clock). Single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_write`  in  1  CPU store strobe, sampled on `posedge clk`.
- `addr`  in  32  CPU data address (the ALU result).
- `write_data`  in  32  CPU store data.
- `read_data`  out  32  combinational read data for `addr`. 0 when `hit` is low.
- `hit`  out  1  combinational; high when `addr` equals TXDATA or STATUS.
- `uart_tx`  out  1  registered serial line, idle high.

## Operation
- Address decode is an exact 32-bit compare; there is no byte-lane decode.
- Store to TXDATA:
  - If the FIFO is not full, or the TX state machine pops in the same cycle, push `write_data[7:0]`.
  - Otherwise drop the byte and set sticky `overflow`.
- Store to STATUS: clears `overflow` regardless of data. It has no other effect.
- Read of TXDATA returns 32'h0.
- Read of STATUS returns `{24'b0, count[3:0], overflow, busy, empty, full}`:
  - bit0 `full`
  - bit1 `empty`
  - bit2 `busy` (state ≠ IDLE)
  - bit3 `overflow`
  - bits[7:4] FIFO occupancy, 0..8
- FIFO: circular buffer with `log2(FIFO_DEPTH)`-bit read/write pointers that wrap modulo depth, plus a separate count register of `log2(FIFO_DEPTH)+1` bits.
  - Push and pop in the same cycle: count unchanged. This is legal at full and at non-empty.
  - Pop never occurs when empty.
- TX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `uart_tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit-index and baud counters, and go to START.
  - START: `uart_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `uart_tx`=`shift[0]`. Every `CLKS_PER_BIT` cycles, shift right and increment the bit index. After 8 bits, go to STOP.
  - STOP: `uart_tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1. The bit boundary is where the count reaches `CLKS_PER_BIT`-1; the counter then returns to 0.

## Timing
- Reset values: `uart_tx`=1, state IDLE, FIFO empty (count 0, pointers 0), `overflow`=0, counters 0.
- Reset asserted mid-frame: the line goes high immediately (asynchronous) and queued bytes are discarded.
- A store at edge N into an empty FIFO with FSM in IDLE:
  - The pop happens at edge N+1.
  - `uart_tx` falls after edge N+1 (1-cycle latency).
  - STATUS shows `empty`=1 again after edge N+1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles of START+DATA+STOP, followed by exactly 1 IDLE cycle when the FIFO is non-empty.
- Back-to-back inter-frame period: 10×`CLKS_PER_BIT`+1 cycles.
- `busy` rises the cycle after the pop edge and falls after the last STOP cycle.
- `read_data`/`hit` have zero latency (combinational on `addr`) and reflect state as of the last edge. A store and a STATUS read in the same cycle return pre-store status.

## Test plan
- Bench uses `CLKS_PER_BIT`=4 throughout.
- Reset values: after reset, `uart_tx`=1 and STATUS reads 32'h0000_0002. Assert reset mid-frame → `uart_tx`=1 asynchronously, STATUS returns to 32'h0000_0002.
- Single byte: store 32'hFFFF_FF55 to 0x8000_0010 at edge N → `uart_tx` low from N+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high. Frame is 40 cycles. `busy` is high for exactly 40 cycles.
- Fill/overflow: 10 back-to-back stores of 0x00..0x09 starting from empty:
  - The first is popped immediately; 0x01..0x08 fill the FIFO and STATUS reads `full`=1, count=8.
  - 0x09 is dropped and `overflow`=1.
  - The line emits 0x00..0x08 in order with 41-cycle frame spacing.
- Push at full with simultaneous pop: with FIFO full at the final STOP→IDLE transition, store at the pop edge → byte accepted, count stays 8, `overflow` stays 0.
- Overflow clear and decode: store any value to 0x8000_0014 → `overflow`=0, no byte queued.
  - Read 0x8000_0018 → `hit`=0, `read_data`=0.
  - Store to 0x8000_0000 → no FIFO change.
- Wrap-around: push/pop 20 bytes 0xA0..0xB3 in staggered bursts of 3 → pointers wrap twice and all 20 bytes appear on the line in order, uncorrupted.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to TXDATA queue bytes in a FIFO; STATUS is pollable.
// Pop one cycle after a store into an idle, empty block; a store to a full FIFO is dropped and sets sticky overflow.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 108,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        uart_tx
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam int          CW          = AW + 1;
    localparam int          BW          = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic          w_hit_data;
    logic          w_hit_status;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_baud_done;
    logic [3:0]    w_count4;
    logic          w_unused;

    assign w_hit_data   = (addr == BASE_ADDR);
    assign w_hit_status = (addr == STATUS_ADDR);
    assign w_full       = (r_count == DEPTH_C);
    assign w_empty      = (r_count == '0);
    assign w_busy       = (r_state != S_IDLE);
    assign w_pop        = (r_state == S_IDLE) && !w_empty;
    assign w_push_req   = mem_write && w_hit_data;
    // A full FIFO still accepts when the FSM frees a slot in the same cycle.
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_baud_done  = (r_baud == BAUD_LAST);
    assign w_count4     = 4'(r_count);
    assign w_unused     = ^write_data[31:8];

    assign hit       = w_hit_data || w_hit_status;
    assign read_data = w_hit_status ? {24'b0, w_count4, r_overflow, w_busy, w_empty, w_full} : 32'h0;
    assign uart_tx   = r_tx;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (mem_write && w_hit_status) begin
                r_overflow <= 1'b0;
            end else if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_START;
                        r_tx      <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
